// File: rtl/data_c_to_axis_pkt.sv
// data_c stream to AXI-Stream master bridge with a small first-word-fall-through FIFO.
// MODE 0 carries sideband inside the data word; MODE 1 builds it from a per-packet length.
module data_c_to_axis_pkt #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1,
  parameter int MODE  = 0,
  parameter int LSIZE = 16,
  parameter int DEPTH = 4,
  parameter int IN_W  = (MODE != 0) ? DSIZE : USIZE + KSIZE + 1 + DSIZE
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LSIZE-1:0]             pkt_len,
  output logic [DSIZE-1:0]             axis_tdata,
  output logic [KSIZE-1:0]             axis_tkeep,
  output logic                         axis_tlast,
  output logic [USIZE-1:0]             axis_tuser,
  output logic                         axis_tvalid,
  input  logic                         axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         pkt_done
);

  localparam int W  = USIZE + KSIZE + 1 + DSIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_next;
  logic             push, pop;
  logic [W-1:0]     head, wr_word, gen_word, in_ext;
  logic [LSIZE-1:0] cnt, len_q, eff_len;
  logic             gen_last;

  assign push        = in_valid & in_ready;
  assign pop         = axis_tvalid & axis_tready;
  assign axis_tvalid = (fifo_count != '0);

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CW'(1);
    else if (pop && !push) count_next = fifo_count - CW'(1);
  end

  // The live length is used on the first beat so single-beat packets close immediately.
  assign eff_len  = (cnt == '0) ? ((pkt_len == '0) ? LSIZE'(1) : pkt_len) : len_q;
  assign gen_last = (cnt == eff_len - LSIZE'(1));
  assign gen_word = {USIZE'(cnt == '0), {KSIZE{1'b1}}, gen_last, in_data[DSIZE-1:0]};
  assign in_ext   = W'(in_data);
  assign wr_word  = (MODE != 0) ? gen_word : in_ext;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b0;
      pkt_done   <= 1'b0;
      cnt        <= '0;
      len_q      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_next;
      in_ready   <= (count_next != CW'(DEPTH));
      pkt_done   <= pop & head[DSIZE];
      if (push) begin
        if (cnt == '0) len_q <= eff_len;
        cnt <= gen_last ? '0 : cnt + LSIZE'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  // Outputs read zero whenever the FIFO is empty, including during reset.
  assign head       = mem[rd_ptr];
  assign axis_tdata = axis_tvalid ? head[DSIZE-1:0] : '0;
  assign axis_tlast = axis_tvalid ? head[DSIZE] : 1'b0;
  assign axis_tkeep = axis_tvalid ? head[DSIZE+1 +: KSIZE] : '0;
  assign axis_tuser = axis_tvalid ? head[DSIZE+1+KSIZE +: USIZE] : '0;

endmodule

// File: tb/tb_data_c_to_axis_pkt.sv
// Bench for data_c_to_axis_pkt: one embedded-sideband and one generated-sideband instance,
// each checked every cycle against a queue-based packet model.
module tb_data_c_to_axis_pkt;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  // embedded-sideband instance
  logic [37:0] in_data_e;
  logic        in_valid_e, in_ready_e, tready_e, tvalid_e, tlast_e, done_e;
  logic [31:0] tdata_e;
  logic [3:0]  tkeep_e;
  logic [0:0]  tuser_e;
  logic [2:0]  count_e;
  logic [15:0] pkt_len_e;

  // generated-sideband instance
  logic [31:0] in_data_g;
  logic        in_valid_g, in_ready_g, tready_g, tvalid_g, tlast_g, done_g;
  logic [31:0] tdata_g;
  logic [3:0]  tkeep_g;
  logic [0:0]  tuser_g;
  logic [2:0]  count_g;
  logic [15:0] pkt_len_g;

  data_c_to_axis_pkt #(.MODE(0), .DEPTH(DEPTH)) u_emb (
    .clock(clock), .rst(rst), .in_data(in_data_e), .in_valid(in_valid_e), .in_ready(in_ready_e),
    .pkt_len(pkt_len_e), .axis_tdata(tdata_e), .axis_tkeep(tkeep_e), .axis_tlast(tlast_e),
    .axis_tuser(tuser_e), .axis_tvalid(tvalid_e), .axis_tready(tready_e),
    .fifo_count(count_e), .pkt_done(done_e));

  data_c_to_axis_pkt #(.MODE(1), .DEPTH(DEPTH)) u_gen (
    .clock(clock), .rst(rst), .in_data(in_data_g), .in_valid(in_valid_g), .in_ready(in_ready_g),
    .pkt_len(pkt_len_g), .axis_tdata(tdata_g), .axis_tkeep(tkeep_g), .axis_tlast(tlast_g),
    .axis_tuser(tuser_g), .axis_tvalid(tvalid_g), .axis_tready(tready_g),
    .fifo_count(count_g), .pkt_done(done_g));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference models ----------------
  logic [37:0] q_e[$];
  logic [37:0] q_g[$];
  logic        exp_rdy_e, exp_rdy_g, exp_done_e, exp_done_g;
  logic        held_e, held_g;
  logic [37:0] held_w_e, held_w_g;
  int          pos, cur_len;
  int          done_cnt_g, sof_cnt_g, last_cnt_g;

  always @(negedge clock) begin
    if (rst) begin
      check("rst_out_e", {tuser_e, tkeep_e, tlast_e, tdata_e, tvalid_e, in_ready_e, done_e, count_e}, '0);
      q_e.delete();
      exp_rdy_e = 1'b0; exp_done_e = 1'b0; held_e = 1'b0;
    end else begin
      check("ready_e", in_ready_e, exp_rdy_e);
      check("tvalid_e", tvalid_e, q_e.size() != 0);
      check("count_e", count_e, q_e.size());
      check("done_e", done_e, exp_done_e);
      if (held_e) check("stable_e", {tuser_e, tkeep_e, tlast_e, tdata_e}, held_w_e);
      exp_done_e = 1'b0; held_e = 1'b0;
      if (tvalid_e && q_e.size() != 0) begin
        check("word_e", {tuser_e, tkeep_e, tlast_e, tdata_e}, q_e[0]);
        if (tready_e) begin
          exp_done_e = q_e[0][32];
          void'(q_e.pop_front());
        end else begin
          held_e = 1'b1; held_w_e = {tuser_e, tkeep_e, tlast_e, tdata_e};
        end
      end
      if (in_valid_e && in_ready_e) q_e.push_back(in_data_e);
      exp_rdy_e = (q_e.size() != DEPTH);
    end
  end

  always @(negedge clock) begin
    logic [37:0] w;
    logic        tl;
    if (rst) begin
      check("rst_out_g", {tuser_g, tkeep_g, tlast_g, tdata_g, tvalid_g, in_ready_g, done_g, count_g}, '0);
      q_g.delete();
      exp_rdy_g = 1'b0; exp_done_g = 1'b0; held_g = 1'b0; pos = 0;
    end else begin
      check("ready_g", in_ready_g, exp_rdy_g);
      check("tvalid_g", tvalid_g, q_g.size() != 0);
      check("count_g", count_g, q_g.size());
      check("done_g", done_g, exp_done_g);
      if (done_g) done_cnt_g++;
      if (held_g) check("stable_g", {tuser_g, tkeep_g, tlast_g, tdata_g}, held_w_g);
      exp_done_g = 1'b0; held_g = 1'b0;
      if (tvalid_g && q_g.size() != 0) begin
        check("word_g", {tuser_g, tkeep_g, tlast_g, tdata_g}, q_g[0]);
        if (tready_g) begin
          exp_done_g = q_g[0][32];
          if (q_g[0][32]) last_cnt_g++;
          if (q_g[0][37]) sof_cnt_g++;
          void'(q_g.pop_front());
        end else begin
          held_g = 1'b1; held_w_g = {tuser_g, tkeep_g, tlast_g, tdata_g};
        end
      end
      if (in_valid_g && in_ready_g) begin
        if (pos == 0) cur_len = (pkt_len_g == 0) ? 1 : int'(pkt_len_g);
        tl = (pos + 1 == cur_len);
        w  = {(pos == 0), 4'hF, tl, in_data_g};
        q_g.push_back(w);
        pos = tl ? 0 : pos + 1;
      end
      exp_rdy_g = (q_g.size() != DEPTH);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    logic was_ready;
    int pv, pr;
    in_data_e = '0; in_valid_e = 0; tready_e = 0; pkt_len_e = '0;
    in_data_g = '0; in_valid_g = 0; tready_g = 0; pkt_len_g = 16'd4;
    done_cnt_g = 0; sof_cnt_g = 0; last_cnt_g = 0;

    repeat (3) cyc();
    check("rst_ready", in_ready_e, 1'b0);
    rst = 1'b0;
    cyc();
    check("ready_rise", in_ready_e, 1'b1);

    // single embedded beat, latency and pkt_done
    tready_e = 1; in_valid_e = 1;
    in_data_e = {1'b1, 4'hF, 1'b1, 32'hDEADBEEF};
    cyc();
    in_valid_e = 0;
    check("t1_word", {tuser_e, tkeep_e, tlast_e, tdata_e, tvalid_e}, {1'b1, 4'hF, 1'b1, 32'hDEADBEEF, 1'b1});
    check("t1_no_done", done_e, 1'b0);
    cyc();
    check("t1_done", done_e, 1'b1);
    cyc();
    check("t1_done_off", done_e, 1'b0);

    // 12 beats of 4-beat packets at full rate
    done_cnt_g = 0; sof_cnt_g = 0; last_cnt_g = 0;
    pkt_len_g = 16'd4; tready_g = 1; in_valid_g = 1;
    for (int i = 0; i < 12; i++) begin
      in_data_g = 32'(100 + i);
      cyc();
    end
    in_valid_g = 0;
    repeat (4) cyc();
    check("t2_done_pulses", done_cnt_g, 3);
    check("t2_sof", sof_cnt_g, 3);
    check("t2_last", last_cnt_g, 3);

    // fill to full, one pop, refill
    tready_e = 0; in_valid_e = 1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_data_e = 38'(acc);
      was_ready = in_ready_e;
      cyc();
      if (was_ready) acc++;
    end
    check("t3_accepted", acc, 4);
    check("t3_count", count_e, 4);
    check("t3_ready_low", in_ready_e, 1'b0);
    in_data_e = 38'(acc);
    tready_e = 1;
    cyc();
    tready_e = 0;
    check("t3_ready_back", in_ready_e, 1'b1);
    cyc();
    in_valid_e = 0;
    check("t3_count_refill", count_e, 4);
    tready_e = 1;
    repeat (6) cyc();

    // degenerate lengths, then mid-packet length change
    sof_cnt_g = 0; last_cnt_g = 0;
    in_valid_g = 1;
    for (int i = 0; i < 8; i++) begin
      pkt_len_g = (i < 4) ? 16'd0 : 16'd1;
      in_data_g = 32'(200 + i);
      cyc();
    end
    in_valid_g = 0;
    repeat (4) cyc();
    check("t4_all_last", last_cnt_g, 8);
    check("t4_all_sof", sof_cnt_g, 8);
    last_cnt_g = 0;
    in_valid_g = 1;
    for (int i = 0; i < 11; i++) begin
      pkt_len_g = (i < 2) ? 16'd5 : 16'd3;
      in_data_g = 32'(300 + i);
      cyc();
    end
    in_valid_g = 0;
    repeat (4) cyc();
    check("t4_last_count", last_cnt_g, 3);

    // random backpressure on both instances
    for (int ph = 0; ph < 20; ph++) begin
      pv = $urandom_range(5, 100);
      pr = $urandom_range(5, 100);
      for (int i = 0; i < 500; i++) begin
        in_valid_e = ($urandom_range(0, 99) < pv);
        in_valid_g = ($urandom_range(0, 99) < pv);
        tready_e   = ($urandom_range(0, 99) < pr);
        tready_g   = ($urandom_range(0, 99) < pr);
        in_data_e  = {6'($urandom), $urandom};
        in_data_g  = $urandom;
        pkt_len_g  = 16'($urandom_range(0, 5));
        cyc();
      end
    end
    in_valid_e = 0; in_valid_g = 0; tready_e = 1; tready_g = 1;
    repeat (8) cyc();
    check("t5_drained_e", count_e, 0);
    check("t5_drained_g", count_g, 0);

    // reset in the middle of a packet
    rst = 1; cyc(); rst = 0; cyc();
    pkt_len_g = 16'd4; tready_g = 0; in_valid_g = 1;
    for (int i = 0; i < 2; i++) begin
      in_data_g = 32'(400 + i);
      cyc();
    end
    in_valid_g = 0;
    check("t6_buffered", count_g, 2);
    rst = 1;
    #1;
    check("t6_async_clear", {tvalid_g, count_g, in_ready_g}, '0);
    cyc(); cyc();
    rst = 0;
    cyc();
    sof_cnt_g = 0; last_cnt_g = 0; done_cnt_g = 0;
    tready_g = 1; in_valid_g = 1;
    for (int i = 0; i < 4; i++) begin
      in_data_g = 32'(500 + i);
      cyc();
    end
    in_valid_g = 0;
    repeat (4) cyc();
    check("t6_sof", sof_cnt_g, 1);
    check("t6_last", last_cnt_g, 1);
    check("t6_done", done_cnt_g, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
